// File: rtl/mem_io_responder.sv
// +-- mem_io_responder : CPU bus responder routing to RAM, LED register and switch port --+
// +-- rev 1.0                                                                          --+
`default_nettype none

module mem_io_responder #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 9,
  parameter int                RAM_WORDS = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [9:0]        sw,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              mem_err,
  output logic [7:0]        ledr
);

  localparam logic [1:0]    c_CMD_NONE  = 2'b00;
  localparam logic [1:0]    c_CMD_READ  = 2'b01;
  localparam logic [1:0]    c_CMD_WRITE = 2'b10;
  localparam logic [1:0]    c_CMD_RSV   = 2'b11;
  localparam int            c_IDX_W     = $clog2(RAM_WORDS);
  localparam logic [ADDR_W:0] c_RAM_TOP = (ADDR_W+1)'(RAM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RDWAIT = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic [9:0]          r_sw_meta;
  logic [9:0]          r_sw_sync;
  logic [DATA_W-1:0]   r_ram [RAM_WORDS];
  logic [DATA_W-1:0]   r_ram_q;

  logic                w_accept;
  logic                w_is_ram;
  logic                w_is_led;
  logic                w_is_sw;
  logic                w_err;
  logic                w_ram_we;
  logic                w_ram_rd;
  logic                w_led_we;
  logic [c_IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0]   w_io_data;

  assign w_accept = (r_state == S_IDLE) && (mem_cmd != c_CMD_NONE);
  assign w_is_ram = {1'b0, mem_addr} < c_RAM_TOP;
  assign w_is_led = (mem_addr == LED_ADDR);
  assign w_is_sw  = (mem_addr == SW_ADDR);
  assign w_err    = (mem_cmd == c_CMD_RSV) ||
                    !(w_is_ram || w_is_led || w_is_sw) ||
                    (w_is_sw && (mem_cmd == c_CMD_WRITE));
  // reset is folded in so the non-reset RAM block cannot write while held in reset
  assign w_ram_we = reset && w_accept && !w_err && w_is_ram && (mem_cmd == c_CMD_WRITE);
  assign w_ram_rd = w_accept && !w_err && w_is_ram && (mem_cmd == c_CMD_READ);
  assign w_led_we = w_accept && !w_err && w_is_led && (mem_cmd == c_CMD_WRITE);
  assign w_idx    = mem_addr[c_IDX_W-1:0];

  always_comb begin
    w_io_data = '0;
    if (!w_err && (mem_cmd == c_CMD_READ)) begin
      if (w_is_led)
        w_io_data = {{(DATA_W-8){1'b0}}, ledr};
      else if (w_is_sw)
        w_io_data = {{(DATA_W-10){1'b0}}, r_sw_sync};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Plain synchronous RAM: registered read port, write-before-later-read ordering
  always_ff @(posedge clk) begin
    if (w_ram_we)
      r_ram[w_idx] <= write_data;
    r_ram_q <= r_ram[w_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      read_data <= '0;
      ledr      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_led_we)
            ledr <= write_data[7:0];
          if (w_ram_rd) begin
            r_state <= S_RDWAIT;
          end else if (w_accept) begin
            r_state   <= S_RESP;
            mem_ready <= 1'b1;
            mem_err   <= w_err;
            read_data <= w_io_data;
          end
        end
        S_RDWAIT: begin
          r_state   <= S_RESP;
          mem_ready <= 1'b1;
          mem_err   <= 1'b0;
          read_data <= r_ram_q;
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          read_data <= '0;
        end
        default: begin
          r_state   <= S_IDLE;
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          read_data <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// +-- tb_mem_io_responder : scoreboard bench for mem_io_responder --+
// +-- rev 1.0                                                     --+
`default_nettype none

module tb_mem_io_responder;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] WRITE = 2'b10;
  localparam logic [1:0] RSV   = 2'b11;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [9:0]  sw;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        mem_err;
  logic [7:0]  ledr;

  typedef struct {
    logic        err;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  mem_io_responder dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .sw         (sw),
    .read_data  (read_data),
    .mem_ready  (mem_ready),
    .mem_err    (mem_err),
    .ledr       (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (mem_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready cyc=%0d err=%0b data=%h required no response", cyc, mem_err, read_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (mem_err !== e.err || read_data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL response cyc=%0d err=%0b data=%h required cyc=%0d err=%0b data=%h",
                   cyc, mem_err, read_data, e.cyc, e.err, e.data);
        end
      end
    end
  end

  task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    mem_cmd    = c;
    mem_addr   = a;
    write_data = d;
  endtask

  task automatic push_exp(input logic e_err, input logic [15:0] e_data, input int lat);
    exp_t e;
    e.err  = e_err;
    e.data = e_data;
    e.cyc  = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (mem_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s ready=0 required ready=1 within 10 cycles", name);
    end
  endtask

  task automatic req(input string name, input logic [1:0] c, input logic [8:0] a,
                     input logic [15:0] d, input logic e_err, input logic [15:0] e_data,
                     input int lat);
    drive(c, a, d);
    push_exp(e_err, e_data, lat);
    wait_ready(name);
    drive(NONE, 9'h000, 16'h0000);
    @(negedge clk);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, act, req_v);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(NONE, 9'h000, 16'h0000);
    sw = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(2'($urandom_range(0, 3)), 9'($urandom), 16'($urandom));
      sw = 10'($urandom);
    end
    @(negedge clk);
    check8("reset_ledr", ledr, 8'h00);
    check8("reset_ready", {7'd0, mem_ready}, 8'h00);
    check8("reset_err", {7'd0, mem_err}, 8'h00);
    check8("reset_rdata_lo", read_data[7:0], 8'h00);
    check8("reset_rdata_hi", read_data[15:8], 8'h00);
    drive(NONE, 9'h000, 16'h0000);
    sw = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // RAM write / read
    req("wr_000", WRITE, 9'h000, 16'h1234, 1'b0, 16'h0000, 1);
    req("wr_0ff", WRITE, 9'h0FF, 16'hABCD, 1'b0, 16'h0000, 1);
    req("rd_0ff", READ,  9'h0FF, 16'h0000, 1'b0, 16'hABCD, 2);
    req("rd_000", READ,  9'h000, 16'h0000, 1'b0, 16'h1234, 2);

    // LED and switches
    req("wr_led", WRITE, 9'h100, 16'hFF5A, 1'b0, 16'h0000, 1);
    check8("ledr_after_write", ledr, 8'h5A);
    req("rd_led", READ,  9'h100, 16'h0000, 1'b0, 16'h005A, 1);
    sw = 10'h2A5;
    repeat (2) @(negedge clk);
    req("rd_sw",  READ,  9'h140, 16'h0000, 1'b0, 16'h02A5, 1);

    // Errors: no side effects
    req("err_rd_101", READ,  9'h101, 16'h0000, 1'b1, 16'h0000, 1);
    req("err_wr_sw",  WRITE, 9'h140, 16'hFFFF, 1'b1, 16'h0000, 1);
    req("err_rsv",    RSV,   9'h000, 16'hDEAD, 1'b1, 16'h0000, 1);
    req("err_rsv_led", RSV,  9'h100, 16'h00C3, 1'b1, 16'h0000, 1);
    check8("ledr_after_errors", ledr, 8'h5A);
    req("rd_000_again", READ, 9'h000, 16'h0000, 1'b0, 16'h1234, 2);

    // Reset during RDWAIT aborts the read
    req("wr_010", WRITE, 9'h010, 16'h0F10, 1'b0, 16'h0000, 1);
    drive(READ, 9'h010, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    drive(NONE, 9'h000, 16'h0000);
    repeat (2) @(negedge clk);
    check8("ready_in_reset", {7'd0, mem_ready}, 8'h00);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check8("ledr_after_reset", ledr, 8'h00);
    req("rd_010", READ, 9'h010, 16'h0000, 1'b0, 16'h0F10, 2);

    // Held command re-executes: responses in cycles 2 and 4
    drive(WRITE, 9'h020, 16'h7777);
    push_exp(1'b0, 16'h0000, 1);
    push_exp(1'b0, 16'h0000, 3);
    repeat (4) @(negedge clk);
    drive(NONE, 9'h000, 16'h0000);
    repeat (3) @(negedge clk);
    req("rd_020", READ, 9'h020, 16'h0000, 1'b0, 16'h7777, 2);

    // Command swapped during RESP is only sampled in the following IDLE
    drive(WRITE, 9'h021, 16'h1111);
    push_exp(1'b0, 16'h0000, 1);
    wait_ready("wr_021");
    drive(READ, 9'h021, 16'h0000);
    push_exp(1'b0, 16'h1111, 3);
    wait_ready("rd_021");
    drive(NONE, 9'h000, 16'h0000);
    repeat (5) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding_responses got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
